// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings for the ID/EX pipeline stage and the ALU.
//   - ALUOp encodings produced by the main decoder
//   - R-type funct codes understood by the ALU
//   - 4-bit ALU Control codes
//   - bit positions inside the 4-bit ctrl bundle {RegWrite, MemRead, MemWrite, MemtoReg}
//   - operand forwarding select helper
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_BAD = 4'b1111
  } alu_ctrl_e;

  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  // Forwarding select for one source register: EX/MEM result beats MEM/WB
  // data, and register 0 is never forwarded.
  function automatic logic [31:0] fwd_select(
    input logic [4:0]  r,
    input logic [31:0] regval,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_val,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_val
  );
    logic [31:0] v;
    v = regval;
    if (r != '0) begin
      if (mem_we && (mem_rd == r))
        v = mem_val;
      else if (wb_we && (wb_rd == r))
        v = wb_val;
    end
    return v;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// alu_control: combinational ALU-control decode.
//   ALUOp   in  2  operation class from the main decoder
//   funct   in  6  R-type function field (used only when ALUOp = R-type)
//   Control out 4  ALU operation code; unknown R-type funct gives 1111
module alu_control
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] Control
);

  always_comb begin
    Control = ALU_BAD;
    case (ALUOp)
      ALUOP_ADD: Control = ALU_ADD;
      ALUOP_SUB: Control = ALU_SUB;
      ALUOP_OR:  Control = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: Control = ALU_ADD;
          FUNCT_SUB: Control = ALU_SUB;
          FUNCT_AND: Control = ALU_AND;
          FUNCT_OR:  Control = ALU_OR;
          FUNCT_SLT: Control = ALU_SLT;
          default:   Control = ALU_BAD;
        endcase
      end
      default: Control = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//   clk, reset          clock; synchronous active-high reset
//   stall, flush        hold the stage / load a bubble
//   id_*                decode-stage instruction fields
//   mem_*, wb_*         EX/MEM and MEM/WB forwarding sources
//   in1, in2            forwarded ALU operands (in2 = imm when ALUSrc)
//   Control             registered ALU operation code
//   ex_store_data       forwarded rt value for stores
//   ex_dest, ex_ctrl,
//   ex_valid            registered destination, control bundle and valid
//   hazard              combinational load-use stall request
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_ctrl,
  input  logic        id_ALUSrc,
  input  logic        id_RegDst,
  input  logic [1:0]  id_ALUOp,
  input  logic [5:0]  id_funct,
  input  logic        mem_RegWrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_Result,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  Control,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_ctrl,
  output logic        ex_valid,
  output logic        hazard
);

  logic [3:0]  id_control;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic        ex_alusrc;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // ALU control is decoded in ID so only the 4-bit code is pipelined.
  alu_control u_alu_control (
    .ALUOp   (id_ALUOp),
    .funct   (id_funct),
    .Control (id_control)
  );

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; request a stall and insert a bubble here.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_dest != '0) &&
        ((ex_dest == id_rs) || (ex_dest == id_rt)))
      hazard = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_dest    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alusrc  <= 1'b0;
      Control    <= ALU_AND;
    end else if (stall) begin
      // hold every field
    end else if (hazard) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_dest    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alusrc  <= 1'b0;
      Control    <= ALU_AND;
    end else begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_ctrl;
      ex_dest    <= id_RegDst ? id_rd : id_rt;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_alusrc  <= id_ALUSrc;
      Control    <= id_control;
    end
  end

  always_comb begin
    fwd_rs = fwd_select(ex_rs, ex_rs_data, mem_RegWrite, mem_rd, mem_Result,
                        wb_RegWrite, wb_rd, wb_data);
    fwd_rt = fwd_select(ex_rt, ex_rt_data, mem_RegWrite, mem_rd, mem_Result,
                        wb_RegWrite, wb_rd, wb_data);
  end

  assign in1           = fwd_rs;
  assign in2           = ex_alusrc ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_ctrl;
  logic        id_ALUSrc, id_RegDst;
  logic [1:0]  id_ALUOp;
  logic [5:0]  id_funct;
  logic        mem_RegWrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_Result;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] in1, in2, ex_store_data;
  logic [3:0]  Control, ex_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, hazard;

  int unsigned n_checks;
  int unsigned n_fail;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUOp(id_ALUOp), .id_funct(id_funct),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_Result(mem_Result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .in1(in1), .in2(in2), .Control(Control), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the contents of the ID/EX latch as a plain record.
  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alusrc;
    logic [3:0]  control;
  } stage_t;

  stage_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [5:0] keys [5];
    logic [3:0] vals [5];
    logic [3:0] r;
    keys = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    vals = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7};
    if (op == 2'd0) return 4'h2;
    if (op == 2'd1) return 4'h6;
    if (op == 2'd3) return 4'h1;
    r = 4'hF;
    for (int i = 0; i < 5; i++)
      if (keys[i] == fn) r = vals[i];
    return r;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] regval);
    if (r == 5'd0) return regval;
    if (mem_RegWrite && mem_rd == r) return mem_Result;
    if (wb_RegWrite && wb_rd == r) return wb_data;
    return regval;
  endfunction

  function automatic logic m_hazard();
    return m.valid && m.ctrl[2] && (m.dest != 5'd0) &&
           ((m.dest == id_rs) || (m.dest == id_rt));
  endfunction

  task automatic settle_check();
    #1;
    check("in1", in1, m_fwd(m.rs, m.rs_data));
    check("in2", in2, m.alusrc ? m.imm : m_fwd(m.rt, m.rt_data));
    check("store_data", ex_store_data, m_fwd(m.rt, m.rt_data));
    check("Control", 32'(Control), 32'(m.control));
    check("ex_dest", 32'(ex_dest), 32'(m.dest));
    check("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("hazard", 32'(hazard), 32'(m_hazard()));
  endtask

  task automatic clock_edge();
    logic hz;
    @(posedge clk);
    hz = m_hazard();
    if (reset || flush) m = '0;
    else if (stall) m = m;
    else if (hz) m = '0;
    else begin
      m.valid   = id_valid;
      m.ctrl    = id_ctrl;
      m.dest    = id_RegDst ? id_rd : id_rt;
      m.rs      = id_rs;
      m.rt      = id_rt;
      m.rs_data = id_rs_data;
      m.rt_data = id_rt_data;
      m.imm     = id_imm;
      m.alusrc  = id_ALUSrc;
      m.control = m_decode(id_ALUOp, id_funct);
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0;
    id_ALUSrc = 0; id_RegDst = 0; id_ALUOp = '0; id_funct = '0;
    mem_RegWrite = 0; mem_rd = '0; mem_Result = '0;
    wb_RegWrite = 0; wb_rd = '0; wb_data = '0;
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_t;

  dec_t sweep [10];

  initial begin
    n_checks = 0;
    n_fail = 0;
    m = '0;
    sweep = '{'{2'b00, 6'h00, 4'h2}, '{2'b01, 6'h00, 4'h6}, '{2'b11, 6'h00, 4'h1},
              '{2'b10, 6'h20, 4'h2}, '{2'b10, 6'h22, 4'h6}, '{2'b10, 6'h24, 4'h0},
              '{2'b10, 6'h25, 4'h1}, '{2'b10, 6'h2a, 4'h7}, '{2'b10, 6'h00, 4'hF},
              '{2'b10, 6'h3f, 4'hF}};

    // Reset
    idle();
    reset = 1;
    clock_edge();
    clock_edge();
    reset = 0;
    settle_check();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_control", 32'(Control), 32'd0);
    check("rst_in1", in1, 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);

    // add r3, r1(5), r2(7)
    id_valid = 1; id_rs = 5'd1; id_rs_data = 32'd5; id_rt = 5'd2; id_rt_data = 32'd7;
    id_rd = 5'd3; id_RegDst = 1; id_ALUOp = 2'b10; id_funct = 6'b100000; id_ctrl = 4'b1000;
    settle_check();
    clock_edge();
    settle_check();
    check("add_in1", in1, 32'd5);
    check("add_in2", in2, 32'd7);
    check("add_control", 32'(Control), 32'h2);
    check("add_dest", 32'(ex_dest), 32'd3);

    // Forwarding priority and register 0
    mem_RegWrite = 1; mem_rd = 5'd1; mem_Result = 32'hAA;
    wb_RegWrite = 1; wb_rd = 5'd1; wb_data = 32'hBB;
    settle_check();
    check("fwd_mem_wins", in1, 32'hAA);
    mem_RegWrite = 0;
    settle_check();
    check("fwd_wb", in1, 32'hBB);
    id_rs = 5'd0; id_rs_data = 32'h11;
    clock_edge();
    mem_RegWrite = 1; mem_rd = 5'd0; wb_rd = 5'd0;
    settle_check();
    check("fwd_r0", in1, 32'h11);

    // Load-use
    idle();
    id_valid = 1; id_ctrl = 4'b1101; id_rt = 5'd4; id_rs = 5'd9;
    clock_edge();
    id_rs = 5'd4; id_rt = 5'd5; id_ctrl = 4'b1000;
    settle_check();
    check("loaduse_hazard", 32'(hazard), 32'd1);
    clock_edge();
    settle_check();
    check("bubble_valid", 32'(ex_valid), 32'd0);
    check("bubble_ctrl", 32'(ex_ctrl), 32'd0);
    id_ctrl = 4'b1101; id_rt = 5'd0; id_rs = 5'd0;
    clock_edge();
    settle_check();
    check("loaduse_r0", 32'(hazard), 32'd0);

    // Immediate operand with rt forwarding active
    idle();
    id_valid = 1; id_ALUSrc = 1; id_imm = 32'hFFFFFFFC; id_rt = 5'd6; id_rt_data = 32'd3;
    clock_edge();
    mem_RegWrite = 1; mem_rd = 5'd6; mem_Result = 32'h1234;
    settle_check();
    check("imm_in2", in2, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'h1234);

    // Stall / flush / reset priority
    idle();
    id_valid = 1; id_rs = 5'd7; id_rs_data = 32'h77; id_rt = 5'd8; id_rt_data = 32'h88;
    id_rd = 5'd9; id_RegDst = 1; id_ctrl = 4'b1000;
    clock_edge();
    idle();
    stall = 1; id_valid = 1; id_rd = 5'd2; id_RegDst = 1; id_rs_data = 32'h5;
    for (int i = 0; i < 2; i++) begin
      clock_edge();
      settle_check();
      check("stall_dest", 32'(ex_dest), 32'd9);
      check("stall_in1", in1, 32'h77);
    end
    flush = 1;
    clock_edge();
    settle_check();
    check("flush_stall_valid", 32'(ex_valid), 32'd0);
    check("flush_stall_dest", 32'(ex_dest), 32'd0);
    flush = 0; stall = 0; id_rs = 5'd3; id_ALUOp = 2'b01;
    clock_edge();
    reset = 1; flush = 1; stall = 1;
    clock_edge();
    reset = 0; flush = 0; stall = 0;
    settle_check();
    check("rfs_valid", 32'(ex_valid), 32'd0);
    check("rfs_control", 32'(Control), 32'd0);
    check("rfs_in1", in1, 32'd0);

    // ALU-control decode sweep
    for (int i = 0; i < 10; i++) begin
      idle();
      id_valid = 1; id_ALUOp = sweep[i].op; id_funct = sweep[i].fn;
      clock_edge();
      settle_check();
      check("decode_sweep", 32'(Control), 32'(sweep[i].exp));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      id_valid = 1'($urandom_range(0, 1));
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_ctrl = 4'($urandom);
      id_ALUSrc = 1'($urandom_range(0, 1));
      id_RegDst = 1'($urandom_range(0, 1));
      id_ALUOp = 2'($urandom);
      id_funct = ($urandom_range(0, 1) == 0) ? sweep[$urandom_range(3, 7)].fn : 6'($urandom);
      mem_RegWrite = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 7));
      mem_Result = $urandom;
      wb_RegWrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      settle_check();
      clock_edge();
    end
    idle();
    settle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold all stage registers.
REQ-005 flush  in  1  load a bubble on the next edge.
REQ-006 id_valid  in  1  decode stage holds a real instruction.
REQ-007 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-008 id_imm  in  32  sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-010 id_ctrl  in  4  {RegWrite, MemRead, MemWrite, MemtoReg}.
REQ-011 id_ALUSrc, id_RegDst  in  1 each  1 = immediate operand; 1 = destination is rd.
REQ-012 id_ALUOp  in  2; id_funct  in  6  ALU control source.
REQ-013 mem_RegWrite  in  1; mem_rd  in  5; mem_Result  in  32  EX/MEM forwarding source.
REQ-014 wb_RegWrite  in  1; wb_rd  in  5; wb_data  in  32  MEM/WB forwarding source.
REQ-015 in1, in2  out  32 each  forwarded ALU operands.
REQ-016 Control  out  4  ALU operation code.
REQ-017 ex_store_data  out  32  forwarded rt value for stores.
REQ-018 ex_dest  out  5; ex_ctrl  out  4; ex_valid  out  1  registered stage fields.
REQ-019 hazard  out  1  combinational load-use stall request to fetch/decode.

Function
REQ-020 Registered fields SHALL be rs_data, rt_data, imm, rs, rt, dest, ctrl, ALUSrc, Control, valid.
REQ-021 Edge priority SHALL be: reset > flush > stall (hold) > hazard (bubble) > load.
REQ-022 A bubble SHALL clear valid, ctrl, dest, rs, rt to 0 and Control to 4'b0000; data fields are don't-care but SHALL be cleared to 0.
REQ-023 dest SHALL be loaded as id_RegDst ? id_rd : id_rt.
REQ-024 Control SHALL be decoded before the register: ALUOp 00->0010, 01->0110, 11->0001, 10->funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, other funct->1111.
REQ-025 hazard SHALL be 1 when ex_valid & ex_ctrl MemRead & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt), else 0.
REQ-026 Forward value for a register r SHALL be: mem_Result if mem_RegWrite & mem_rd==r & r!=0; else wb_data if wb_RegWrite & wb_rd==r & r!=0; else the registered read data.
REQ-027 in1 SHALL be the forward value for rs; ex_store_data the forward value for rt.
REQ-028 in2 SHALL be registered imm when ALUSrc=1, else the forward value for rt.
REQ-029 Register 0 SHALL never be forwarded; MEM SHALL win over WB when both match.
REQ-030 Latency: decode inputs appear on registered outputs one cycle after capture; forwarding is zero-latency combinational.

Reset
REQ-031 On reset all registered fields SHALL be 0 (Control 4'b0000, ex_valid 0), so in1=in2=ex_store_data=0 unless forwarded; reset mid-stall SHALL override the hold.
REQ-032 hazard SHALL read 0 the cycle after reset.

Structure
REQ-033 ALUOp encodings, funct codes and 4-bit Control codes SHALL live in a shared package used by this block and the ALU.
REQ-034 ALU-control decode SHALL be one sub-module, alu_control (ALUOp, funct -> Control).

Verification
REQ-035 Load: add rs=1(5), rt=2(7), rd=3, ALUOp 10, funct 100000 -> next cycle in1=5, in2=7, Control=0010, ex_dest=3.
REQ-036 Forwarding: mem_rd=1 mem_Result=0xAA, wb_rd=1 wb_data=0xBB, both RegWrite -> in1=0xAA; clear mem_RegWrite -> in1=0xBB; rs=0 with rd=0 matches -> in1 unchanged.
REQ-037 Load-use: ex holds lw dest=4, id_rs=4 -> hazard=1, next edge ex_valid=0, ex_ctrl=0; dest=0 -> hazard=0.
REQ-038 Immediate: ALUSrc=1, imm=0xFFFFFFFC, rt forwarding active -> in2=0xFFFFFFFC, ex_store_data=forwarded value.
REQ-039 Priority: stall=1 holds all fields two cycles; flush+stall -> bubble; reset+flush+stall -> all 0.
REQ-040 Decode sweep: every ALUOp/funct pair of REQ-024 plus funct 000000 -> Control matches table, unknown -> 1111.
